// File: rtl/iq_accum.sv
// iq_accum: pairs IQ-serialized samples, sums 2**log_n complete pairs and emits
// the rounded (half-up) mean as one IQ-serialized output pair with its own gate.
// Malformed pairing is reported through a sticky orphan flag.
module iq_accum #(
  parameter int dw    = 18,
  parameter int log_n = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate_in,
  input  logic                 iq,
  input  logic signed [dw-1:0] z,
  input  logic                 clear,
  output logic signed [dw-1:0] avg,
  output logic                 avg_iq,
  output logic                 avg_gate,
  output logic [log_n-1:0]     cnt,
  output logic                 orphan
);

  // Accumulator width: a full block of extreme samples cannot overflow it.
  localparam int aw = dw + log_n;
  localparam logic [log_n-1:0]  cnt_last_c = {log_n{1'b1}};
  localparam logic signed [aw:0] half_c    = {{aw{1'b0}}, 1'b1} << (log_n - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    HAVE_I = 1'b1
  } pair_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_I    = 2'd1,
    OUT_Q    = 2'd2
  } out_phase_t;

  pair_state_t          state_r, state_nxt_s;
  out_phase_t           out_phase_r;
  logic signed [dw-1:0] i_hold_r;
  logic signed [aw-1:0] acc_i_r, acc_q_r;
  logic signed [aw-1:0] sum_i_r, sum_q_r;
  logic signed [aw-1:0] acc_i_nxt_s, acc_q_nxt_s;
  logic [log_n-1:0]     cnt_r;
  logic                 orphan_r;
  logic signed [dw-1:0] avg_r;
  logic                 avg_iq_r, avg_gate_r;
  logic                 pair_s, orphan_set_s, load_i_s, dump_s;
  logic signed [aw:0]   rnd_i_s, rnd_q_s;
  logic signed [dw-1:0] mean_i_s, mean_q_s;

  // Pairing FSM next-state and per-cycle events (pair done, orphan, I latch).
  always_comb begin
    state_nxt_s  = state_r;
    pair_s       = 1'b0;
    orphan_set_s = 1'b0;
    load_i_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (gate_in && iq) begin
          load_i_s    = 1'b1;
          state_nxt_s = HAVE_I;
        end else if (gate_in) begin
          orphan_set_s = 1'b1;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HAVE_I: begin
        if (!gate_in) begin
          orphan_set_s = 1'b1;
          state_nxt_s  = IDLE;
        end else if (iq) begin
          orphan_set_s = 1'b1;
          load_i_s     = 1'b1;
          state_nxt_s  = HAVE_I;
        end else begin
          pair_s      = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Running sums including the current pair, and the block-end strobe.
  always_comb begin
    acc_i_nxt_s = acc_i_r + {{log_n{i_hold_r[dw-1]}}, i_hold_r};
    acc_q_nxt_s = acc_q_r + {{log_n{z[dw-1]}}, z};
    dump_s      = pair_s && !clear && (cnt_r == cnt_last_c);
  end

  // Round half up: add half an LSB of the mean, then arithmetic shift.
  always_comb begin
    rnd_i_s  = {sum_i_r[aw-1], sum_i_r} + half_c;
    rnd_q_s  = {sum_q_r[aw-1], sum_q_r} + half_c;
    mean_i_s = dw'(rnd_i_s >>> log_n);
    mean_q_s = dw'(rnd_q_s >>> log_n);
  end

  // Pairing state and held I sample; clear forces the FSM back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      i_hold_r <= '0;
    end else begin
      if (clear) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_nxt_s;
      end
      if (load_i_s) begin
        i_hold_r <= z;
      end
    end
  end

  // Accumulate pairs; on the last pair of a block snapshot the sums and restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_r <= '0;
      acc_q_r <= '0;
      sum_i_r <= '0;
      sum_q_r <= '0;
      cnt_r   <= '0;
    end else if (clear) begin
      acc_i_r <= '0;
      acc_q_r <= '0;
      cnt_r   <= '0;
    end else if (pair_s) begin
      if (cnt_r == cnt_last_c) begin
        sum_i_r <= acc_i_nxt_s;
        sum_q_r <= acc_q_nxt_s;
        acc_i_r <= '0;
        acc_q_r <= '0;
        cnt_r   <= '0;
      end else begin
        acc_i_r <= acc_i_nxt_s;
        acc_q_r <= acc_q_nxt_s;
        cnt_r   <= cnt_r + log_n'(1'b1);
      end
    end
  end

  // Sticky orphan flag; only clear or reset drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orphan_r <= 1'b0;
    end else if (clear) begin
      orphan_r <= 1'b0;
    end else if (orphan_set_s) begin
      orphan_r <= 1'b1;
    end
  end

  // Output sequencer: I mean, then Q mean, then gate drops with avg held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_phase_r <= OUT_IDLE;
      avg_r       <= '0;
      avg_iq_r    <= 1'b0;
      avg_gate_r  <= 1'b0;
    end else begin
      case (out_phase_r)
        OUT_I: begin
          avg_r       <= mean_i_s;
          avg_iq_r    <= 1'b1;
          avg_gate_r  <= 1'b1;
          out_phase_r <= OUT_Q;
        end
        OUT_Q: begin
          avg_r       <= mean_q_s;
          avg_iq_r    <= 1'b0;
          avg_gate_r  <= 1'b1;
          out_phase_r <= OUT_IDLE;
        end
        OUT_IDLE: begin
          avg_iq_r    <= 1'b0;
          avg_gate_r  <= 1'b0;
          out_phase_r <= dump_s ? OUT_I : OUT_IDLE;
        end
        default: begin
          avg_iq_r    <= 1'b0;
          avg_gate_r  <= 1'b0;
          out_phase_r <= OUT_IDLE;
        end
      endcase
    end
  end

  assign avg      = avg_r;
  assign avg_iq   = avg_iq_r;
  assign avg_gate = avg_gate_r;
  assign cnt      = cnt_r;
  assign orphan   = orphan_r;

endmodule
